// File: rtl/mips_mem_arb.sv
// mips_mem_arb: round-robin sequencer sharing one byte-wide memory port between
// the multicycle MIPS core (requester 0) and the byte loader (requester 1).

// Per-requester response slice: ack decode and the read-data holding register.
module mips_mem_arb_port #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          sel,
  input  logic          done,
  input  logic          cap,
  input  logic [DW-1:0] mem_rdata,
  output logic          ack,
  output logic [DW-1:0] rdata
);
  assign ack = done & sel;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)         rdata <= '0;
    else if (cap && sel) rdata <= mem_rdata;
  end
endmodule

module mips_mem_arb #(
  parameter int AW          = 8,
  parameter int DW          = 8,
  parameter int WAIT_CYCLES = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_ack,
  output logic [DW-1:0] cpu_rdata,
  input  logic          ld_req,
  input  logic          ld_we,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_wdata,
  output logic          ld_ack,
  output logic [DW-1:0] ld_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          owner,
  output logic          busy
);
  localparam int NREQ = 2;
  localparam int CW   = 4;
  localparam logic [CW-1:0] CNT_LOAD = CW'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2} state_t;
  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } xact_t;

  state_t                  state, state_nxt;
  xact_t [NREQ-1:0]        rq;
  xact_t                   lat_q;
  logic  [NREQ-1:0]        req_v, ack_v;
  logic  [NREQ-1:0][DW-1:0] rdata_v;
  logic                    own_q, own_nxt, grant, cap;
  logic  [CW-1:0]          cnt_q;

  assign req_v = {ld_req, cpu_req};
  assign rq[0] = {cpu_we, cpu_addr, cpu_wdata};
  assign rq[1] = {ld_we, ld_addr, ld_wdata};

  // On a tie the requester that did not hold the last grant wins.
  always_comb begin
    state_nxt = state;
    own_nxt   = own_q;
    grant     = 1'b0;
    case (state)
      IDLE: if (|req_v) begin
        grant     = 1'b1;
        own_nxt   = (&req_v) ? ~own_q : req_v[1];
        state_nxt = ACCESS;
      end
      ACCESS:  if (cnt_q == '0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      own_q <= 1'b1;
      cnt_q <= '0;
      lat_q <= '0;
    end else begin
      state <= state_nxt;
      own_q <= own_nxt;
      if (grant) begin
        lat_q <= rq[own_nxt];
        cnt_q <= CNT_LOAD;
      end else if (state == ACCESS && cnt_q != '0) begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

  // Read data is taken in the final access cycle, when the macro output is valid.
  assign cap = (state == ACCESS) && (cnt_q == '0) && !lat_q.we;

  for (genvar i = 0; i < NREQ; i++) begin : g_port
    mips_mem_arb_port #(.DW(DW)) u_port (
      .clk       (clk),
      .reset     (reset),
      .sel       (own_q == 1'(i)),
      .done      (state == DONE),
      .cap       (cap),
      .mem_rdata (mem_rdata),
      .ack       (ack_v[i]),
      .rdata     (rdata_v[i])
    );
  end

  assign mem_en    = (state == ACCESS);
  assign mem_we    = mem_en & lat_q.we;
  assign mem_addr  = mem_en ? lat_q.addr  : '0;
  assign mem_wdata = mem_en ? lat_q.wdata : '0;
  assign cpu_ack   = ack_v[0];
  assign ld_ack    = ack_v[1];
  assign cpu_rdata = rdata_v[0];
  assign ld_rdata  = rdata_v[1];
  assign owner     = own_q;
  assign busy      = (state != IDLE);
endmodule

// File: tb/tb_mips_mem_arb.sv
// Bench for mips_mem_arb: two instances (1 and 3 wait cycles) driven in lockstep,
// checked against a transaction-level timing/memory model.
module tb_mips_mem_arb;
  localparam int AW = 8, DW = 8;
  localparam int W0 = 1, W1 = 3;

  logic clk = 1'b0;
  logic reset;
  logic [1:0][1:0]         req, we, ack;
  logic [1:0][1:0][AW-1:0] addr;
  logic [1:0][1:0][DW-1:0] wdata, rdata;
  logic [1:0]              mem_en, mem_we, owner, busy;
  logic [1:0][AW-1:0]      mem_addr;
  logic [1:0][DW-1:0]      mem_wdata, mem_rdata;
  logic [DW-1:0]           mem [2][256];

  int n_cmp = 0, n_err = 0, cyc = 0;
  bit autodrv = 0;

  always #5 clk = ~clk;

  for (genvar d = 0; d < 2; d++) begin : g_dut
    mips_mem_arb #(.AW(AW), .DW(DW), .WAIT_CYCLES(d == 0 ? W0 : W1)) u_dut (
      .clk(clk), .reset(reset),
      .cpu_req(req[d][0]), .cpu_we(we[d][0]), .cpu_addr(addr[d][0]), .cpu_wdata(wdata[d][0]),
      .cpu_ack(ack[d][0]), .cpu_rdata(rdata[d][0]),
      .ld_req(req[d][1]), .ld_we(we[d][1]), .ld_addr(addr[d][1]), .ld_wdata(wdata[d][1]),
      .ld_ack(ack[d][1]), .ld_rdata(rdata[d][1]),
      .mem_en(mem_en[d]), .mem_we(mem_we[d]), .mem_addr(mem_addr[d]), .mem_wdata(mem_wdata[d]),
      .mem_rdata(mem_rdata[d]), .owner(owner[d]), .busy(busy[d])
    );
    assign mem_rdata[d] = mem[d][mem_addr[d]];
  end

  // Memory macro model; contents refill to a known pattern while reset is held.
  always @(posedge clk or negedge reset)
    for (int d = 0; d < 2; d++)
      if (!reset) for (int i = 0; i < 256; i++) mem[d][i] <= 8'(i) ^ 8'hB5;
      else if (mem_en[d] && mem_we[d]) mem[d][mem_addr[d]] <= mem_wdata[d];

  // Reference model state
  int            age[2], cur[2], last[2];
  logic          m_we[2];
  logic [AW-1:0] m_addr[2];
  logic [DW-1:0] m_wdata[2];
  logic [DW-1:0] exp_rd[2][2];
  logic [DW-1:0] ref_mem[2][256];
  // Observations
  int en_cnt[2], ackc[2][2], addr_chg[2];
  int rise[2][$], oq[2][$], ackt[2][$], aq[2][$];
  bit prev_en[2];
  logic [AW-1:0] last_maddr[2];

  function automatic int wc(input int d);
    return (d == 0) ? W0 : W1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      age[d] = -1; cur[d] = 0; last[d] = 1;
      exp_rd[d][0] = '0; exp_rd[d][1] = '0;
      for (int i = 0; i < 256; i++) ref_mem[d][i] = 8'(i) ^ 8'hB5;
    end
  endtask

  task automatic clr();
    for (int d = 0; d < 2; d++) begin
      en_cnt[d] = 0; ackc[d][0] = 0; ackc[d][1] = 0; addr_chg[d] = 0;
      rise[d].delete(); oq[d].delete(); ackt[d].delete(); aq[d].delete();
    end
  endtask

  task automatic new_txn(input int d, input int r);
    req[d][r]   = 1'b1;
    we[d][r]    = 1'($urandom_range(0, 1));
    addr[d][r]  = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom);
    wdata[d][r] = 8'($urandom);
  endtask

  task automatic put(input int r, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] wd);
    for (int d = 0; d < 2; d++) begin
      req[d][r] = 1'b1; we[d][r] = w; addr[d][r] = a; wdata[d][r] = wd;
    end
  endtask

  // One clock: advance the model on the edge, compare, then (optionally) drive.
  task automatic tick();
    @(posedge clk); #1;
    cyc++;
    for (int d = 0; d < 2; d++) begin
      logic e_en, e_we, e_busy;
      logic [1:0] e_ack;
      if (reset) begin
        if (age[d] >= 0) age[d]++;
        if (age[d] == wc(d) + 2) age[d] = -1;
        if (age[d] == -1 && req[d] != 2'b00) begin
          cur[d]     = (req[d] == 2'b11) ? 1 - last[d] : int'(req[d][1]);
          last[d]    = cur[d];
          age[d]     = 0;
          m_we[d]    = we[d][cur[d]];
          m_addr[d]  = addr[d][cur[d]];
          m_wdata[d] = wdata[d][cur[d]];
        end
      end
      e_en   = (age[d] >= 0) && (age[d] < wc(d));
      e_we   = e_en && m_we[d];
      e_ack  = (age[d] == wc(d)) ? ((cur[d] == 1) ? 2'b10 : 2'b01) : 2'b00;
      e_busy = (age[d] >= 0) && (age[d] <= wc(d));
      if (e_ack != 2'b00) begin
        if (m_we[d]) ref_mem[d][m_addr[d]] = m_wdata[d];
        else         exp_rd[d][cur[d]]    = ref_mem[d][m_addr[d]];
      end
      chk($sformatf("ctl[%0d] en,we,ack,busy,owner", d),
          {mem_en[d], mem_we[d], ack[d], busy[d], owner[d]},
          {e_en, e_we, e_ack, e_busy, 1'(last[d])});
      if (e_en) begin
        chk($sformatf("addr[%0d]", d), mem_addr[d], m_addr[d]);
        if (m_we[d]) chk($sformatf("wdata[%0d]", d), mem_wdata[d], m_wdata[d]);
      end
      if (!reset) chk($sformatf("rst_out[%0d]", d), {mem_addr[d], mem_wdata[d]}, 16'h0);
      chk($sformatf("rdata[%0d]", d), {rdata[d][1], rdata[d][0]}, {exp_rd[d][1], exp_rd[d][0]});

      en_cnt[d] += int'(mem_en[d]);
      if (mem_en[d] && !prev_en[d]) begin
        rise[d].push_back(cyc);
        oq[d].push_back(int'(owner[d]));
      end
      if (mem_en[d] && prev_en[d] && mem_addr[d] != last_maddr[d]) addr_chg[d]++;
      if (mem_en[d]) last_maddr[d] = mem_addr[d];
      prev_en[d] = mem_en[d];
      for (int r = 0; r < 2; r++)
        if (ack[d][r]) begin
          ackc[d][r]++; ackt[d].push_back(cyc); aq[d].push_back(r);
        end
    end
    if (autodrv)
      for (int d = 0; d < 2; d++)
        for (int r = 0; r < 2; r++) begin
          bit infl;
          infl = (age[d] >= 0) && (age[d] < wc(d)) && (cur[d] == r);
          if (ack[d][r]) begin
            if ($urandom_range(0, 2) == 0) new_txn(d, r);
            else req[d][r] = 1'b0;
          end else if (infl && req[d][r]) begin
            // latched at grant: scrambling or dropping must not disturb the access
            addr[d][r]  = 8'($urandom);
            wdata[d][r] = 8'($urandom);
            we[d][r]    = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) req[d][r] = 1'b0;
          end else if (!req[d][r] && !(age[d] >= 0 && age[d] <= wc(d) && cur[d] == r)) begin
            if ($urandom_range(0, 3) == 0) new_txn(d, r);
          end
        end
  endtask

  task automatic drain(input int bound);
    int n;
    bit done;
    n = 0;
    do begin
      tick(); n++;
      done = 1;
      for (int d = 0; d < 2; d++) begin
        for (int r = 0; r < 2; r++) if (ack[d][r]) req[d][r] = 1'b0;
        if (req[d] != 2'b00 || (age[d] >= 0 && age[d] <= wc(d))) done = 0;
      end
    end while (!done && n < bound);
    chk("drain_timeout", 32'(done), 32'd1);
  endtask

  initial begin
    int n, s;
    reset = 1'b0;
    req = '0; we = '0; addr = '0; wdata = '0;
    model_reset();
    repeat (3) tick();
    reset = 1'b1;

    // single cpu read
    clr(); put(0, 1'b0, 8'h10, 8'h00); drain(20);
    for (int d = 0; d < 2; d++) begin
      chk("t1_en_cycles", en_cnt[d], wc(d));
      chk("t1_cpu_ack", ackc[d][0], 1);
      chk("t1_ld_ack", ackc[d][1], 0);
      chk("t1_rdata", rdata[d][0], 8'hA5);
    end

    // loader write to the top address
    clr(); s = cyc; put(1, 1'b1, 8'hFF, 8'h3C); drain(20);
    for (int d = 0; d < 2; d++) begin
      chk("t2_en_cycles", en_cnt[d], wc(d));
      chk("t2_ack_cycle", ackt[d][0], s + 1 + wc(d));
      chk("t2_ld_ack", ackc[d][1], 1);
      chk("t2_mem", mem[d][8'hFF], 8'h3C);
      chk("t2_cpu_rdata", rdata[d][0], 8'hA5);
    end

    // contention: both held for four grants
    clr(); put(0, 1'b0, 8'h30, 8'h00); put(1, 1'b0, 8'h31, 8'h00);
    n = 0;
    while ((rise[0].size() < 4 || rise[1].size() < 4) && n < 60) begin
      tick(); n++;
      for (int d = 0; d < 2; d++) if (rise[d].size() >= 4) req[d] = 2'b00;
    end
    drain(30);
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 4; i++) begin
        chk("t3_ack_order", aq[d][i], i % 2);
        chk("t3_owner", oq[d][i], i % 2);
      end
      for (int i = 0; i < 3; i++) chk("t3_spacing", rise[d][i+1] - rise[d][i], wc(d) + 2);
      chk("t3_acks", ackc[d][0] + ackc[d][1], 4);
    end

    // inputs changed mid-access have no effect
    clr(); put(0, 1'b0, 8'h20, 8'h00); tick();
    for (int d = 0; d < 2; d++) addr[d][0] = 8'h40;
    drain(20);
    for (int d = 0; d < 2; d++) begin
      chk("t4_addr_change", addr_chg[d], 0);
      chk("t4_addr", last_maddr[d], 8'h20);
      chk("t4_rdata", rdata[d][0], 8'h95);
    end

    // async reset in the middle of an access
    clr(); put(0, 1'b0, 8'h50, 8'h00); tick();
    put(1, 1'b0, 8'h60, 8'h00); tick();
    chk("t5_pre_en", mem_en[1], 1'b1);
    reset = 1'b0; #1;
    for (int d = 0; d < 2; d++) begin
      chk("t5_async_en", mem_en[d], 1'b0);
      chk("t5_async_we", mem_we[d], 1'b0);
      chk("t5_async_ack", ack[d], 2'b00);
      chk("t5_async_owner", owner[d], 1'b1);
      req[d][0] = 1'b0;
    end
    model_reset();
    tick();
    reset = 1'b1;
    clr(); drain(20);
    for (int d = 0; d < 2; d++) begin
      chk("t5_ld_ack", ackc[d][1], 1);
      chk("t5_cpu_ack", ackc[d][0], 0);
      chk("t5_ld_rdata", rdata[d][1], 8'hD5);
    end

    // back-to-back: cpu keeps req high through the first ack
    clr(); put(0, 1'b0, 8'h70, 8'h00);
    n = 0;
    while ((ackc[0][0] < 2 || ackc[1][0] < 2) && n < 40) begin
      tick(); n++;
      for (int d = 0; d < 2; d++) if (ackc[d][0] >= 2) req[d][0] = 1'b0;
    end
    drain(20);
    for (int d = 0; d < 2; d++) begin
      chk("t6_acks", ackc[d][0], 2);
      chk("t6_ack_to_en", rise[d][1] - ackt[d][0], 2);
    end

    // randomized traffic
    clr(); autodrv = 1;
    repeat (3000) tick();
    autodrv = 0;
    drain(100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
